// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C register-file slave.
// State encoding, bus ACK levels and address-byte layout.
package i2c_slave_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_INDEX,
    ST_WDATA,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_slave_byte_engine.sv
// I2C bit/byte engine: START/STOP detect, byte shift in/out,
// slave ACK drive and master ACK sample. No register-file policy here.
module i2c_slave_byte_engine
  import i2c_slave_regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  input  logic       ack_req,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       start,
  output logic       stop,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       ack_in,
  output logic       master_ack,
  output logic       sda_out
);

  logic       scl_q;
  logic       sda_q;
  logic [3:0] cnt;
  logic [6:0] sh;
  logic [7:0] tx_sh;
  logic       tx_mode;
  logic       scl_rise;
  logic       scl_fall;

  assign scl_rise   = scl & ~scl_q;
  assign scl_fall   = ~scl & scl_q;
  assign start      = scl & scl_q & sda_q & ~sda_in;
  assign stop       = scl & scl_q & ~sda_q & sda_in;
  assign rx_byte    = {sh, sda_in};
  assign rx_valid   = scl_rise && (cnt == 4'd7);
  assign ack_in     = scl_rise && (cnt == 4'd8) && tx_mode;
  assign master_ack = (sda_in == ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      cnt     <= 4'd0;
      sh      <= 7'd0;
      tx_sh   <= 8'hff;
      tx_mode <= 1'b0;
      sda_out <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda_in;
      if (start || stop) begin
        cnt     <= 4'd0;
        tx_mode <= 1'b0;
        sda_out <= 1'b1;
      end else if (scl_rise) begin
        sh  <= rx_byte[6:0];
        cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
      end else if (scl_fall) begin
        // cnt==8: ninth-bit slot; cnt==0: first bit of next byte
        if (cnt == 4'd8) begin
          sda_out <= tx_mode ? NACK : (ack_req ? ACK : NACK);
        end else if (cnt == 4'd0) begin
          tx_mode <= tx_load;
          sda_out <= tx_load ? tx_byte[7] : 1'b1;
          tx_sh   <= {tx_byte[6:0], 1'b1};
        end else begin
          sda_out <= tx_mode ? tx_sh[7] : 1'b1;
          tx_sh   <= {tx_sh[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers with an index pointer,
// auto-increment writes and sequential read-back.
module i2c_slave_regfile #(
  parameter logic [6:0]            I2C_ADDRESS   = 7'h00,
  parameter int                    NUM_REGS      = 8,
  parameter int                    PTR_WIDTH     = 3,
  parameter logic [NUM_REGS*8-1:0] DEFAULT_VALUE = '0,
  parameter int                    READ_SOURCE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  input  logic [NUM_REGS*8-1:0] reg_in,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]   reg_strobe,
  output logic                  busy
);

  import i2c_slave_regfile_pkg::*;

  state_t                  state;
  logic [PTR_WIDTH-1:0]    ptr;
  logic [PTR_WIDTH-1:0]    ptr_next;
  logic                    ack_req;
  logic                    start;
  logic                    stop;
  logic                    rx_valid;
  logic [7:0]              rx_byte;
  logic                    ack_in;
  logic                    master_ack;
  logic                    tx_load;
  logic [7:0]              tx_byte;
  logic [NUM_REGS*8-1:0]   tx_src;

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_REGS - 1);

  assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  assign tx_src   = (READ_SOURCE != 0) ? reg_in : reg_out;
  assign tx_byte  = tx_src[{ptr, 3'b000} +: 8];
  assign tx_load  = (state == ST_RDATA);

  i2c_slave_byte_engine u_engine (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda_in     (sda_in),
    .ack_req    (ack_req),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .start      (start),
    .stop       (stop),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .ack_in     (ack_in),
    .master_ack (master_ack),
    .sda_out    (sda_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      ack_req    <= 1'b0;
      busy       <= 1'b0;
      reg_out    <= DEFAULT_VALUE;
      reg_strobe <= '0;
    end else begin
      reg_strobe <= '0;
      if (stop) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        ack_req <= 1'b0;
      end else if (start) begin
        state   <= ST_ADDR;
        ack_req <= 1'b0;
      end else if (rx_valid) begin
        ack_req <= 1'b0;
        unique case (state)
          ST_ADDR: begin
            if (rx_byte[7:1] == I2C_ADDRESS) begin
              ack_req <= 1'b1;
              busy    <= 1'b1;
              state   <= rx_byte[RW_BIT] ? ST_RDATA : ST_INDEX;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_INDEX: begin
            if (32'(rx_byte) < NUM_REGS) begin
              ptr     <= rx_byte[PTR_WIDTH-1:0];
              ack_req <= 1'b1;
              state   <= ST_WDATA;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_WDATA: begin
            reg_out[{ptr, 3'b000} +: 8] <= rx_byte;
            reg_strobe[ptr]             <= 1'b1;
            ptr                         <= ptr_next;
            ack_req                     <= 1'b1;
          end
          // our own shifted-out byte completes the data phase
          ST_RDATA: state <= ST_RACK;
          default: ;
        endcase
      end else if (ack_in && state == ST_RACK) begin
        if (master_ack) begin
          ptr   <= ptr_next;
          state <= ST_RDATA;
        end else begin
          state <= ST_IGNORE;
        end
      end
    end
  end

endmodule
